// File: rtl/cr_ram1_req_coalescer.sv
// Merges single-word RAM1 read requests with consecutive addresses into burst
// commands {4'b0, len, start_addr} written into the RAM1 read-engine command FIFO.
module cr_ram1_req_coalescer #(
  parameter int MAX_LEN = 15,
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [7:0]  req_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        flush,
  output logic [15:0] fifo_data,
  output logic        fifo_wr,
  input  logic        fifo_full,
  output logic        busy
);

  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);
  localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

  logic        acc_valid_reg, acc_valid_next;
  logic [7:0]  acc_start_reg, acc_start_next;
  logic [3:0]  acc_len_reg, acc_len_next;
  logic        out_valid_reg, out_valid_next;
  logic [15:0] out_data_reg, out_data_next;
  logic [7:0]  idle_cnt_reg, idle_cnt_next;
  logic        flush_pend_reg, flush_pend_next;

  logic [7:0]  next_addr;
  logic        consec;
  logic        close_req;
  logic        slot_free;
  logic        accept;
  logic        do_close;
  logic        do_extend;
  logic        do_open;

  // The 8-bit sum wraps naturally, so a burst may run through 0xFF -> 0x00.
  assign next_addr = acc_start_reg + {4'b0000, acc_len_reg};
  assign consec    = acc_valid_reg & (req_addr == next_addr);
  assign slot_free = ~out_valid_reg | ~fifo_full;
  assign close_req = acc_valid_reg & ((acc_len_reg == MAX_LEN_L) |
                                      (idle_cnt_reg == TIMEOUT_L) |
                                      flush_pend_reg |
                                      (req_valid & ~consec));

  assign req_ready = ~reset_p & (~acc_valid_reg |
                                 (consec & (acc_len_reg < MAX_LEN_L)) |
                                 slot_free);
  assign accept    = req_valid & req_ready;

  // A non-extending request is only accepted with slot_free, so it always
  // coincides with a close and opens the next burst in the same cycle.
  assign do_close  = close_req & slot_free;
  assign do_extend = ~do_close & accept & consec;
  assign do_open   = accept & (~acc_valid_reg | do_close);

  assign fifo_wr   = ~reset_p & out_valid_reg & ~fifo_full;
  assign fifo_data = reset_p ? 16'h0000 : out_data_reg;
  assign busy      = ~reset_p & (acc_valid_reg | out_valid_reg);

  always_comb begin
    acc_valid_next  = acc_valid_reg;
    acc_start_next  = acc_start_reg;
    acc_len_next    = acc_len_reg;
    out_valid_next  = out_valid_reg;
    out_data_next   = out_data_reg;
    idle_cnt_next   = idle_cnt_reg;
    flush_pend_next = flush_pend_reg;

    if (do_close) begin
      out_valid_next = 1'b1;
      out_data_next  = {4'b0000, acc_len_reg, acc_start_reg};
      acc_valid_next = 1'b0;
    end else if (fifo_wr) begin
      out_valid_next = 1'b0;
    end

    if (do_open) begin
      acc_valid_next = 1'b1;
      acc_start_next = req_addr;
      acc_len_next   = 4'd1;
    end else if (do_extend) begin
      acc_len_next = acc_len_reg + 4'd1;
    end

    if (accept) begin
      idle_cnt_next = 8'd0;
    end else if (acc_valid_reg && (idle_cnt_reg != TIMEOUT_L)) begin
      idle_cnt_next = idle_cnt_reg + 8'd1;
    end

    // A flush arriving with a freshly opened burst targets that new burst.
    if (flush & (accept | (acc_valid_reg & ~do_close))) begin
      flush_pend_next = 1'b1;
    end else if (do_close) begin
      flush_pend_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      acc_valid_reg  <= 1'b0;
      acc_start_reg  <= 8'd0;
      acc_len_reg    <= 4'd0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= 16'd0;
      idle_cnt_reg   <= 8'd0;
      flush_pend_reg <= 1'b0;
    end else begin
      acc_valid_reg  <= acc_valid_next;
      acc_start_reg  <= acc_start_next;
      acc_len_reg    <= acc_len_next;
      out_valid_reg  <= out_valid_next;
      out_data_reg   <= out_data_next;
      idle_cnt_reg   <= idle_cnt_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

endmodule

// File: tb/tb_cr_ram1_req_coalescer.sv
// Directed bench for cr_ram1_req_coalescer (MAX_LEN=15, TIMEOUT=4); inputs change
// 1 ns after the rising edge, outputs are checked 2 ns after it.
module tb_cr_ram1_req_coalescer;

  logic        clk;
  logic        reset_p;
  logic [7:0]  req_addr;
  logic        req_valid;
  logic        req_ready;
  logic        flush;
  logic [15:0] fifo_data;
  logic        fifo_wr;
  logic        fifo_full;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] wr_log[$];

  cr_ram1_req_coalescer #(.MAX_LEN(15), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .req_addr  (req_addr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .flush     (flush),
    .fifo_data (fifo_data),
    .fifo_wr   (fifo_wr),
    .fifo_full (fifo_full),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr === 1'b1) begin
      wr_log.push_back(fifo_data);
      $display("write fifo_data=%04h", fifo_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic f, input logic full);
    req_valid = v;
    req_addr  = a;
    flush     = f;
    fifo_full = full;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%04h expected=%04h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 16'hFFFF;
  endfunction

  initial begin
    logic [7:0] a;
    reset_p = 1'b1;
    req_valid = 1'b0; req_addr = 8'h00; flush = 1'b0; fifo_full = 1'b0;

    // Reset state, with a request presented
    tick(); tick();
    drive(1, 8'h10, 0, 0);
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_wr",    16'(fifo_wr),   16'h0);
    chk("rst_busy",  16'(busy),      16'h0);
    chk("rst_data",  fifo_data,      16'h0000);
    tick();
    reset_p = 1'b0;

    // Single request, closed by the timeout: write at cycle 6, idle at cycle 7
    drive(1, 8'h10, 0, 0);
    chk("t1_ready", 16'(req_ready), 16'h1);
    tick();
    drive(0, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      chk("t1_nowr", 16'(fifo_wr), 16'h0);
      tick();
    end
    chk("t1_wr",   16'(fifo_wr), 16'h1);
    chk("t1_data", fifo_data,    16'h0110);
    chk("t1_busy", 16'(busy),    16'h1);
    tick();
    chk("t1_idle", 16'(busy),    16'h0);

    // Five back-to-back consecutive requests -> one command
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      a = 8'h20 + 8'(i);
      drive(1, a, 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0);
    repeat (10) tick();
    chk("t2_cnt",  16'(wr_log.size()), 16'd1);
    chk("t2_data", log_at(0),          16'h0520);

    // 17 consecutive from 0xF8 through the wrap -> MAX_LEN burst then len 2
    wr_log.delete();
    for (int i = 0; i < 17; i++) begin
      a = 8'hF8 + 8'(i);
      drive(1, a, 0, 0);
      chk("t3_ready", 16'(req_ready), 16'h1);
      tick();
    end
    drive(0, 8'h00, 0, 0);
    repeat (10) tick();
    chk("t3_cnt",   16'(wr_log.size()), 16'd2);
    chk("t3_data0", log_at(0),          16'h0FF8);
    chk("t3_data1", log_at(1),          16'h0207);

    // Break in the run: close and open in the same cycle
    wr_log.delete();
    drive(1, 8'h30, 0, 0); tick();
    drive(1, 8'h31, 0, 0); tick();
    drive(1, 8'h40, 0, 0);
    chk("t4_ready", 16'(req_ready), 16'h1);
    chk("t4_nowr",  16'(fifo_wr),   16'h0);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("t4_wr0",   16'(fifo_wr),   16'h1);
    chk("t4_data0", fifo_data,      16'h0230);
    tick();
    for (int i = 4; i <= 7; i++) begin
      chk("t4_nowr_to", 16'(fifo_wr), 16'h0);
      tick();
    end
    chk("t4_wr1",   16'(fifo_wr), 16'h1);
    chk("t4_data1", fifo_data,    16'h0140);
    tick();

    // FIFO full: slot holds 0x0150, 0x60 accumulates, 0x70 is held off
    wr_log.delete();
    drive(1, 8'h50, 0, 1);
    chk("t5_ready50", 16'(req_ready), 16'h1);
    tick();
    drive(1, 8'h60, 0, 1);
    chk("t5_ready60", 16'(req_ready), 16'h1);
    tick();
    drive(1, 8'h70, 0, 1);
    chk("t5_ready70", 16'(req_ready), 16'h0);
    chk("t5_nowr",    16'(fifo_wr),   16'h0);
    chk("t5_slot",    fifo_data,      16'h0150);
    tick();
    drive(1, 8'h70, 0, 1);
    chk("t5_hold",    16'(req_ready), 16'h0);
    tick();
    drive(1, 8'h70, 0, 0);
    chk("t5_rel_ready", 16'(req_ready), 16'h1);
    chk("t5_rel_wr",    16'(fifo_wr),   16'h1);
    chk("t5_rel_data",  fifo_data,      16'h0150);
    tick();
    drive(0, 8'h00, 0, 0);
    chk("t5_wr60",   16'(fifo_wr), 16'h1);
    chk("t5_data60", fifo_data,    16'h0160);
    repeat (10) tick();
    chk("t5_cnt",   16'(wr_log.size()), 16'd3);
    chk("t5_ord0",  log_at(0),          16'h0150);
    chk("t5_ord1",  log_at(1),          16'h0160);
    chk("t5_ord2",  log_at(2),          16'h0170);

    // Flush closes an open burst early
    wr_log.delete();
    drive(1, 8'h80, 0, 0); tick();
    drive(1, 8'h81, 1, 0); tick();
    drive(0, 8'h00, 0, 0);
    chk("t6_nowr", 16'(fifo_wr), 16'h0);
    tick();
    chk("t6_wr",   16'(fifo_wr), 16'h1);
    chk("t6_data", fifo_data,    16'h0280);
    repeat (8) tick();
    chk("t6_cnt",  16'(wr_log.size()), 16'd1);

    // Flush with nothing open is ignored: next burst still waits for the timeout
    drive(0, 8'h00, 1, 0); tick();
    drive(1, 8'h90, 0, 0); tick();
    drive(0, 8'h00, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      chk("t6b_nowr", 16'(fifo_wr), 16'h0);
      tick();
    end
    chk("t6b_wr",   16'(fifo_wr), 16'h1);
    chk("t6b_data", fifo_data,    16'h0190);
    repeat (3) tick();

    // Reset mid-burst discards the burst
    wr_log.delete();
    drive(1, 8'h80, 0, 0); tick();
    drive(1, 8'h81, 0, 0); tick();
    reset_p = 1'b1;
    drive(0, 8'h00, 0, 0);
    chk("t7_rst_busy",  16'(busy),      16'h0);
    chk("t7_rst_ready", 16'(req_ready), 16'h0);
    tick();
    reset_p = 1'b0;
    #1;
    chk("t7_busy", 16'(busy),    16'h0);
    chk("t7_wr",   16'(fifo_wr), 16'h0);
    repeat (10) tick();
    chk("t7_cnt",  16'(wr_log.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
